// File: rtl/frame_pkg.sv
// ---------------------------------------------------------------------------
// frame_pkg
// Constants and types shared by the receive frame synchroniser, the transmit
// framer and the 4x4 block deinterleaver.
//   fs_state_e     : synchroniser FSM encoding (HUNT / VERIFY / LOCK)
//   *_DEF          : default frame geometry and lock thresholds
//   SYNC_TOL       : mismatch budget used when FRAME_SYNC_TOL_EN is defined
//   frame_len()    : total frame length (payload + sync field) in bits
// ---------------------------------------------------------------------------
package frame_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } fs_state_e;

  localparam int          SYNC_LEN_DEF  = 16;
  localparam logic [15:0] SYNC_WORD_DEF = 16'hEB90;  // MSB goes on air first
  localparam int          BLK_LEN_DEF   = 16;        // one 4x4 interleaver block
  localparam int          PAY_BLKS_DEF  = 4;
  localparam int          VERIFY_N_DEF  = 2;
  localparam int          LOSS_N_DEF    = 3;

  // Bit errors tolerated in a sync word once the frame position is known.
  localparam int          SYNC_TOL      = 1;

  // Payload first, sync field last: the sync check point closes the frame.
  function automatic int frame_len(input int pay_blks, input int blk_len,
                                   input int sync_len);
    return pay_blks * blk_len + sync_len;
  endfunction

endpackage

// File: rtl/sync_corr.sv
// ---------------------------------------------------------------------------
// sync_corr
// Combinational sync-word correlator.
//   cand_i      in  SYNC_LEN  candidate word, oldest bit in the MSB
//   sync_word_i in  SYNC_LEN  reference sync pattern
//   exact_o     out 1         cand_i equals sync_word_i bit for bit
//   tol_hit_o   out 1         with FRAME_SYNC_TOL_EN: popcount(cand ^ sync)
//                             <= SYNC_TOL; without it: same as exact_o
// Configuration macro: FRAME_SYNC_TOL_EN (builds the popcount tree).
// ---------------------------------------------------------------------------
module sync_corr
  import frame_pkg::*;
#(
  parameter int SYNC_LEN = SYNC_LEN_DEF
) (
  input  logic [SYNC_LEN-1:0] cand_i,
  input  logic [SYNC_LEN-1:0] sync_word_i,
  output logic                exact_o,
  output logic                tol_hit_o
);

  assign exact_o = (cand_i == sync_word_i);

`ifdef FRAME_SYNC_TOL_EN
  localparam int MW = $clog2(SYNC_LEN + 1);

  logic [SYNC_LEN-1:0] diff;
  logic [MW-1:0]       mism;

  always_comb begin
    diff = cand_i ^ sync_word_i;
    mism = '0;
    for (int i = 0; i < SYNC_LEN; i++) begin
      mism = mism + MW'(diff[i]);
    end
  end

  assign tol_hit_o = (mism <= MW'(SYNC_TOL));
`else
  // No tolerance: a hit is an exact match and no popcount is built.
  assign tol_hit_o = exact_o;
`endif

endmodule

// File: rtl/frame_sync.sv
// ---------------------------------------------------------------------------
// frame_sync
// Receive-side frame synchroniser feeding the 4x4 block deinterleaver.
// Finds the sync word in the raw bit stream, confirms it over VERIFY_N
// frames, then forwards only payload bits, flagging the first bit of every
// BLK_LEN block. Frame layout (cnt): 0..PAY_LEN-1 payload, then SYNC_LEN
// sync bits; cnt == FRAME_LEN-1 is the sync check point.
//
// Ports
//   clk          in  1  one input bit per rising edge
//   rst          in  1  asynchronous reset, active-high
//   data_i       in  1  serial received hard-decision bit
//   data_o       out 1  data_i delayed by one clock
//   valid_o      out 1  data_o is a payload bit of a locked frame
//   blk_start_o  out 1  data_o is bit 0 of a block (only with valid_o)
//   locked_o     out 1  FSM is (entering / staying) in LOCK
//   sync_miss_o  out 1  one-cycle pulse: sync missing at a LOCK check point
//   state_o      out 2  debug view of the FSM state (fs_state_e encoding)
//
// Stream semantics: valid_o is a pure strobe with no ready/back-pressure;
// a bit is consumed downstream on every cycle valid_o is high, and valid_o
// only changes on frame boundaries (or reset), so whole blocks are delivered.
//
// Configuration macro: FRAME_SYNC_TOL_EN -- VERIFY/LOCK accept up to
// SYNC_TOL bit errors in the sync word; HUNT always needs an exact match.
// ---------------------------------------------------------------------------
module frame_sync
  import frame_pkg::*;
#(
  parameter int                SYNC_LEN  = SYNC_LEN_DEF,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int                BLK_LEN   = BLK_LEN_DEF,
  parameter int                PAY_BLKS  = PAY_BLKS_DEF,
  parameter int                VERIFY_N  = VERIFY_N_DEF,
  parameter int                LOSS_N    = LOSS_N_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_i,
  output logic       data_o,
  output logic       valid_o,
  output logic       blk_start_o,
  output logic       locked_o,
  output logic       sync_miss_o,
  output logic [1:0] state_o
);

  localparam int PAY_LEN   = PAY_BLKS * BLK_LEN;
  localparam int FRAME_LEN = frame_len(PAY_BLKS, BLK_LEN, SYNC_LEN);
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam int HIT_W     = $clog2(VERIFY_N + 1);
  localparam int MISS_W    = $clog2(LOSS_N + 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  fs_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HIT_W-1:0]    hits_q, hits_d;
  logic [MISS_W-1:0]   misses_q, misses_d;
  // Only the previous SYNC_LEN-1 bits are ever needed: the current bit
  // comes straight from data_i to complete the candidate word.
  logic [SYNC_LEN-2:0] sr_q, sr_d;

  logic data_q, valid_q, blk_q, locked_q, miss_q;
  logic valid_d, blk_d, locked_d, miss_d;

  // -------------------------------------------------------------------------
  // Correlation
  // -------------------------------------------------------------------------
  logic [SYNC_LEN-1:0] cand;
  logic                exact;
  logic                frame_hit;

  assign cand = {sr_q, data_i};
  assign sr_d = cand[SYNC_LEN-2:0];

  sync_corr #(
    .SYNC_LEN (SYNC_LEN)
  ) u_corr (
    .cand_i      (cand),
    .sync_word_i (SYNC_WORD),
    .exact_o     (exact),
    .tol_hit_o   (frame_hit)
  );

  // -------------------------------------------------------------------------
  // Frame position
  // -------------------------------------------------------------------------
  logic             at_chk;
  logic             in_pay;
  logic [CNT_W-1:0] cnt_inc;

  assign at_chk  = (cnt_q == CNT_W'(FRAME_LEN - 1));
  assign in_pay  = (cnt_q < CNT_W'(PAY_LEN));
  assign cnt_inc = at_chk ? '0 : cnt_q + CNT_W'(1);

  // -------------------------------------------------------------------------
  // FSM next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hits_d   = hits_q;
    misses_d = misses_q;
    miss_d   = 1'b0;

    unique case (state_q)
      HUNT: begin
        // Frame position is unknown, so the counter is parked and every
        // bit is a potential end of sync. Only an exact match acquires.
        cnt_d    = '0;
        hits_d   = '0;
        misses_d = '0;
        if (exact) begin
          state_d = VERIFY;
          hits_d  = HIT_W'(1);
        end
      end

      VERIFY: begin
        cnt_d = cnt_inc;
        if (at_chk) begin
          if (frame_hit) begin
            if (hits_q != HIT_W'(VERIFY_N)) begin
              hits_d = hits_q + HIT_W'(1);
            end
            if (hits_q >= HIT_W'(VERIFY_N - 1)) begin
              state_d  = LOCK;
              misses_d = '0;
            end
          end else begin
            // Candidate alignment was false. The check-point bit itself is
            // not offered to HUNT; searching resumes with the next bit.
            state_d = HUNT;
            cnt_d   = '0;
            hits_d  = '0;
          end
        end
      end

      LOCK: begin
        // Flywheel: the counter keeps running through missed sync words so
        // payload keeps flowing until LOSS_N consecutive misses.
        cnt_d = cnt_inc;
        if (at_chk) begin
          if (frame_hit) begin
            misses_d = '0;
          end else begin
            miss_d = 1'b1;
            if (misses_q != MISS_W'(LOSS_N)) begin
              misses_d = misses_q + MISS_W'(1);
            end
            if (misses_q >= MISS_W'(LOSS_N - 1)) begin
              state_d  = HUNT;
              cnt_d    = '0;
              hits_d   = '0;
              misses_d = '0;
            end
          end
        end
      end

      default: begin
        state_d  = HUNT;
        cnt_d    = '0;
        hits_d   = '0;
        misses_d = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output terms (registered below, one clock after data_i)
  // -------------------------------------------------------------------------
  always_comb begin
    valid_d  = (state_q == LOCK) && in_pay;
    blk_d    = valid_d && ((cnt_q % CNT_W'(BLK_LEN)) == CNT_W'(0));
    locked_d = (state_d == LOCK);
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      cnt_q    <= '0;
      hits_q   <= '0;
      misses_q <= '0;
      sr_q     <= '0;
      data_q   <= 1'b0;
      valid_q  <= 1'b0;
      blk_q    <= 1'b0;
      locked_q <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
      sr_q     <= sr_d;
      data_q   <= data_i;
      valid_q  <= valid_d;
      blk_q    <= blk_d;
      locked_q <= locked_d;
      miss_q   <= miss_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign blk_start_o = blk_q;
  assign locked_o    = locked_q;
  assign sync_miss_o = miss_q;
  assign state_o     = state_q;

endmodule
